// File: rtl/stopwatch_pkg.sv
// Shared constants and types for the stopwatch front end (key debounce + tick divider).
// Latency: n/a (package only).
// Backpressure: n/a; every consumer of these types is a free-running pulse/level source.
package stopwatch_pkg;

    // Board has four push-buttons; key3 is the start/stop key that realigns the tick.
    localparam int NUM_KEYS        = 4;
    localparam int START_KEY       = 3;

    localparam int DEF_CLK_HZ      = 50_000_000;
    localparam int DEF_TICK_HZ     = 100;
    localparam int DEF_DEBOUNCE_MS = 20;

    // Registered per-key outputs of one debouncer lane.
    typedef struct packed {
        logic level;    // debounced state, 1 = pressed
        logic press;    // one-cycle pulse on accepted press
        logic rls;      // one-cycle pulse on accepted release
    } key_state_t;

    // ceil(log2(value)) with a floor of one bit, for counter sizing.
    function automatic int cnt_width(input int value);
        if (value <= 2) begin
            return 1;
        end
        return $clog2(value);
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Purpose: one push-button lane: 2-flop synchronizer, stability counter, press/release pulses.
// Latency: level and pulse appear 2+DB_CYCLES edges after the first edge that samples a change.
// Backpressure: none; pulses are fire-and-forget, one cycle wide.
// Ports: clk, rst_n (async active-low), i_key_n (raw button, low = pressed),
//        o_state (registered level/press/rls, see key_state_t).
module key_debounce
    import stopwatch_pkg::*;
#(
    parameter int DB_CYCLES = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_key_n,
    output key_state_t o_state
);

    // The counter must be able to hold DB_CYCLES itself: acceptance happens on the
    // edge after it reaches that value, which is what sets the 2+DB_CYCLES latency.
    localparam int               CNT_W   = cnt_width(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES);

    logic [1:0]       r_sync;     // [0] first stage, [1] second stage
    logic [CNT_W-1:0] r_cnt;
    logic             r_level;
    logic             r_press;
    logic             r_release;
    logic             w_sample;   // synchronized sample, 1 = pressed

    assign w_sample = ~r_sync[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Synchronizer parks at "released" so a key held through reset is seen
            // as a fresh press and counts from zero.
            r_sync    <= 2'b11;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], i_key_n};
            r_press   <= 1'b0;
            r_release <= 1'b0;
            if (w_sample == r_level) begin
                // Any sample agreeing with the accepted level throws away partial counts.
                r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
                r_cnt     <= '0;
                r_level   <= w_sample;
                r_press   <= w_sample;
                r_release <= ~w_sample;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_state.level = r_level;
    assign o_state.press = r_press;
    assign o_state.rls   = r_release;

endmodule

// File: rtl/stopwatch_frontend.sv
// Purpose: stopwatch front end: four debounced keys plus a centisecond tick divider.
// Latency: key pulses 2+DB_CYCLES edges after input change; tick every TICK_DIV edges.
// Backpressure: none; all outputs are registered one-cycle pulses or levels.
// Ports: clk, rst_n (async active-low), key_n[3:0] (raw, low = pressed),
//        key_level/key_press/key_release[3:0] (high = pressed / pulse), tick (advance strobe).
module stopwatch_frontend
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ      = DEF_CLK_HZ,
    parameter int TICK_HZ     = DEF_TICK_HZ,
    parameter int DEBOUNCE_MS = DEF_DEBOUNCE_MS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] key_n,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                tick
);

    localparam int TICK_DIV  = CLK_HZ / TICK_HZ;
    localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int DIV_W     = cnt_width(TICK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    // ------------------------------------------------------------------
    // Key lanes: fully independent, so simultaneous acceptances pulse together.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_state_t w_state;

        key_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_key_n (key_n[g]),
            .o_state (w_state)
        );

        assign key_level[g]   = w_state.level;
        assign key_press[g]   = w_state.press;
        assign key_release[g] = w_state.rls;
    end

    // ------------------------------------------------------------------
    // Tick divider. The strobe is the registered terminal-count decode, so it
    // lands TICK_DIV edges after reset release or after a realignment restart.
    // A start/stop press restarts the count so the first period is full length;
    // a terminal count that coincides with that press is dropped rather than
    // producing a runt tick right at the start/stop instant.
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] r_div;
    logic             r_tick;
    logic             w_div_last;
    logic             w_restart;

    assign w_div_last = (r_div == DIV_LAST);
    assign w_restart  = key_press[START_KEY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div  <= '0;
            r_tick <= 1'b0;
        end else begin
            r_tick <= w_div_last & ~w_restart;
            if (w_restart || w_div_last) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end
        end
    end

    assign tick = r_tick;

endmodule

// File: tb/tb_stopwatch_frontend.sv
module tb_stopwatch_frontend;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic [3:0] key_level;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic       tick;

    stopwatch_frontend #(
        .CLK_HZ      (1000),
        .TICK_HZ     (100),
        .DEBOUNCE_MS (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_n       (key_n),
        .key_level   (key_level),
        .key_press   (key_press),
        .key_release (key_release),
        .tick        (tick)
    );

    always #5 clk = ~clk;

    typedef enum int {EV_PRESS, EV_REL, EV_TICK} ev_kind_e;

    typedef struct {
        ev_kind_e kind;
        int       key;
        int       at;
    } ev_t;

    // One table row: keys in mask follow pat (bit i = pressed before edge i),
    // then all released from edge 24 on; expected pulse edges, -1 = none.
    typedef struct {
        string      name;
        logic [3:0] mask;
        logic [23:0] pat;
        int         press_at;
        int         rel_at;
    } vec_t;

    ev_t  exp_q[$];
    vec_t vecs[6];
    int   checks   = 0;
    int   errors   = 0;
    int   cur_edge = 0;
    bit   mon_en   = 1'b0;
    bit   tick_en  = 1'b0;

    function automatic void push_ev(input ev_kind_e k, input int key, input int at);
        ev_t e;
        e.kind = k;
        e.key  = key;
        e.at   = at;
        exp_q.push_back(e);
    endfunction

    function automatic void check_ev(input ev_kind_e k, input int key);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got %s key%0d at edge %0d, required no pulse",
                     k.name(), key, cur_edge);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.key != key || e.at != cur_edge) begin
                errors++;
                $display("FAIL event_order: got %s key%0d at edge %0d, required %s key%0d at edge %0d",
                         k.name(), key, cur_edge, e.kind.name(), e.key, e.at);
            end
        end
    endfunction

    // Scoreboard side: every observed pulse pops and is compared with the next expectation.
    always @(posedge clk) begin
        #2;
        if (mon_en) begin
            for (int k = 0; k < 4; k++) begin
                if (key_press[k]) begin
                    check_ev(EV_PRESS, k);
                    checks++;
                    if (key_level[k] !== 1'b1) begin
                        errors++;
                        $display("FAIL level_at_press key%0d edge %0d: got %b, required 1",
                                 k, cur_edge, key_level[k]);
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                if (key_release[k]) begin
                    check_ev(EV_REL, k);
                    checks++;
                    if (key_level[k] !== 1'b0) begin
                        errors++;
                        $display("FAIL level_at_release key%0d edge %0d: got %b, required 0",
                                 k, cur_edge, key_level[k]);
                    end
                end
            end
            if (tick_en && tick) begin
                check_ev(EV_TICK, 0);
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if ({key_level, key_press, key_release, tick} !== 13'b0) begin
            errors++;
            $display("FAIL %s: got level=%b press=%b release=%b tick=%b, required all 0",
                     name, key_level, key_press, key_release, tick);
        end
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected pulses never seen (first %s key%0d edge %0d), required 0",
                     name, exp_q.size(), exp_q[0].kind.name(), exp_q[0].key, exp_q[0].at);
        end
    endtask

    task automatic check_level(input string name, input logic [3:0] want);
        checks++;
        if (key_level !== want) begin
            errors++;
            $display("FAIL %s_level: got %b, required %b", name, key_level, want);
        end
    endtask

    // Leaves the bench at a falling edge with rst_n low and keys released.
    task automatic do_reset();
        mon_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        key_n = 4'hF;
        repeat (3) @(negedge clk);
        check_zero("reset_state");
        exp_q.delete();
    endtask

    // Releases reset (if low) before edge 'first'; keys in mask pressed on edges low_from..low_to.
    task automatic drive_window(input int first, input int last, input logic [3:0] mask,
                                input int low_from, input int low_to);
        for (int e = first; e <= last; e++) begin
            key_n    = (e >= low_from && e <= low_to) ? ~mask : 4'hF;
            cur_edge = e;
            if (e == first) rst_n = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"clean_k2",     4'b0100, 24'hFFFFFF,  7, 31};
        vecs[1] = '{"bounce_k1",    4'b0010, 24'hFFFFF7, 11, 31};
        vecs[2] = '{"glitch5_k0",   4'b0001, 24'h00001F, -1, -1};
        vecs[3] = '{"min6_k0",      4'b0001, 24'h00003F,  7, 13};
        vecs[4] = '{"multi_k310",   4'b1011, 24'hFFFFFF,  7, 31};
        vecs[5] = '{"relbounce_k3", 4'b1000, 24'h002FFF,  7, 21};

        // Table-driven key patterns.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            tick_en = 1'b0;
            for (int k = 0; k < 4; k++)
                if (vecs[v].mask[k] && vecs[v].press_at >= 0) push_ev(EV_PRESS, k, vecs[v].press_at);
            for (int k = 0; k < 4; k++)
                if (vecs[v].mask[k] && vecs[v].rel_at >= 0) push_ev(EV_REL, k, vecs[v].rel_at);
            mon_en = 1'b1;
            for (int i = 0; i < 40; i++) begin
                logic pressed;
                pressed  = (i < 24) ? vecs[v].pat[i] : 1'b0;
                key_n    = pressed ? ~vecs[v].mask : 4'hF;
                cur_edge = i;
                if (i == 0) rst_n = 1'b1;
                @(negedge clk);
            end
            mon_en = 1'b0;
            check_drained(vecs[v].name);
            check_level(vecs[v].name, 4'b0000);
        end

        // Tick cadence after reset, then realignment by a start/stop press.
        do_reset();
        push_ev(EV_TICK, 0, 10);
        push_ev(EV_TICK, 0, 20);
        push_ev(EV_PRESS, 3, 25);
        push_ev(EV_TICK, 0, 36);
        push_ev(EV_TICK, 0, 46);
        push_ev(EV_REL, 3, 48);
        push_ev(EV_TICK, 0, 56);
        tick_en = 1'b1;
        mon_en  = 1'b1;
        drive_window(1, 60, 4'b1000, 18, 40);
        mon_en  = 1'b0;
        check_drained("tick_realign");

        // Start/stop press coinciding with terminal count: that tick is dropped.
        do_reset();
        push_ev(EV_TICK, 0, 10);
        push_ev(EV_TICK, 0, 20);
        push_ev(EV_PRESS, 3, 29);
        push_ev(EV_TICK, 0, 40);
        push_ev(EV_TICK, 0, 50);
        tick_en = 1'b1;
        mon_en  = 1'b1;
        drive_window(1, 55, 4'b1000, 22, 55);
        mon_en  = 1'b0;
        check_drained("tick_collision");

        // Reset pulsed mid-debounce with key0 held: partial count discarded.
        do_reset();
        tick_en = 1'b0;
        mon_en  = 1'b1;
        drive_window(0, 3, 4'b0001, 0, 99);
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_zero("midreset_outputs");
        push_ev(EV_PRESS, 0, 7);
        drive_window(0, 12, 4'b0001, 0, 99);
        mon_en = 1'b0;
        check_drained("midreset");
        check_level("midreset", 4'b0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
